keypad_scan_ctrl: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and decodes each accepted key to a hex digit. It produces the two-digit history feeding `dual_seg_driver`: `s1` is the newest key and `s2` is the previous one. It is the sequencing controller that sits between the keypad pins and the display multiplexer, sharing the same `clk`/`reset`.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_decoder.sv | 12 +
 rtl/keypad_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } keypad_state_t;

    // Nibble {row,col} holds the legend printed on that key; r0c0 sits in bits [3:0].
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic onehot_valid(input logic [NUM_ROWS-1:0] v);
        logic ok;
        case (v)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] onehot_index(input logic [NUM_ROWS-1:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational lookup from a latched row/column index pair to its hex legend.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] key
);

    assign key = KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner with press/release debounce and a two-key history.
// Define KEYPAD_SYNC_EN for the two-flop row synchronizer; otherwise one register.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic [3:0]          s1,
    output logic [3:0]          s2,
    output logic                key_valid
);

    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);
    localparam logic [DW_W-1:0] DW_ZERO = DW_W'(0);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

    logic [NUM_ROWS-1:0] rows_sync_s;
    logic [3:0]          key_s;

    keypad_state_t       state_r;
    logic [DW_W-1:0]     dwell_r;
    logic [DB_W-1:0]     db_r;
    logic [1:0]          col_idx_r;
    logic [1:0]          row_idx_r;
    logic [NUM_ROWS-1:0] row_pat_r;
    logic [NUM_COLS-1:0] cols_r;
    logic [3:0]          s1_r;
    logic [3:0]          s2_r;
    logic                key_valid_r;

`ifdef KEYPAD_SYNC_EN
    logic [NUM_ROWS-1:0] sync1_r;
    logic [NUM_ROWS-1:0] sync2_r;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= rows;
            sync2_r <= sync1_r;
        end
    end

    assign rows_sync_s = sync2_r;
`else
    logic [NUM_ROWS-1:0] sync1_r;

    // Single capture register for the row inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 4'hF;
        end else begin
            sync1_r <= rows;
        end
    end

    assign rows_sync_s = sync1_r;
`endif

    keypad_decoder u_decoder (
        .row_idx (row_idx_r),
        .col_idx (col_idx_r),
        .key     (key_s)
    );

    // Scan / debounce sequencer; the column stays frozen from detection until release settles
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= SCAN;
            dwell_r     <= DW_ZERO;
            db_r        <= DB_ZERO;
            col_idx_r   <= 2'd0;
            row_idx_r   <= 2'd0;
            row_pat_r   <= 4'hF;
            cols_r      <= 4'b1110;
            s1_r        <= 4'h0;
            s2_r        <= 4'h0;
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (dwell_r == DW_LAST) begin
                        dwell_r <= DW_ZERO;
                        if (onehot_valid(~rows_sync_s)) begin
                            row_pat_r <= rows_sync_s;
                            row_idx_r <= onehot_index(~rows_sync_s);
                            db_r      <= DB_ZERO;
                            state_r   <= PRESS_DB;
                        end else begin
                            cols_r    <= {cols_r[2:0], cols_r[3]};
                            col_idx_r <= col_idx_r + 2'd1;
                        end
                    end else begin
                        dwell_r <= dwell_r + DW_ONE;
                    end
                end
                PRESS_DB: begin
                    if (rows_sync_s != row_pat_r) begin
                        db_r    <= DB_ZERO;
                        dwell_r <= DW_ZERO;
                        state_r <= SCAN;
                    end else if (db_r == DB_LAST) begin
                        s2_r        <= s1_r;
                        s1_r        <= key_s;
                        key_valid_r <= 1'b1;
                        db_r        <= DB_ZERO;
                        state_r     <= HELD;
                    end else begin
                        db_r <= db_r + DB_ONE;
                    end
                end
                HELD: begin
                    if (rows_sync_s == 4'hF) begin
                        db_r    <= DB_ZERO;
                        state_r <= RELEASE_DB;
                    end else begin
                        db_r <= DB_ZERO;
                    end
                end
                RELEASE_DB: begin
                    if (rows_sync_s != 4'hF) begin
                        db_r <= DB_ZERO;
                    end else if (db_r == DB_LAST) begin
                        db_r      <= DB_ZERO;
                        dwell_r   <= DW_ZERO;
                        cols_r    <= {cols_r[2:0], cols_r[3]};
                        col_idx_r <= col_idx_r + 2'd1;
                        state_r   <= SCAN;
                    end else begin
                        db_r <= db_r + DB_ONE;
                    end
                end
                default: begin
                    db_r    <= DB_ZERO;
                    dwell_r <= DW_ZERO;
                    state_r <= SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_r;
    assign s1        = s1_r;
    assign s2        = s2_r;
    assign key_valid = key_valid_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a physical keypad model drives rows from cols,
// and expected timing/keys come from an interval-level model of the scan/debounce rules.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DB = 8;
`ifdef KEYPAD_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       key_valid;

    logic [15:0] pressed = 16'h0000;
    logic        glitch  = 1'b0;
    int cyc = 0;
    int cyc0 = 0;
    int pulse_cnt = 0;
    int pulse_k = -1;
    int n_cmp = 0;
    int n_bad = 0;

    // Legend per key, index row*4+col, as printed on the keypad
    logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .s1(s1), .s2(s2), .key_valid(key_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_k   <= cyc - cyc0;
        end
    end

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
        if (glitch) rows = 4'hF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int now_k();
        return cyc - cyc0;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        pressed = 16'h0000;
        glitch = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        cyc0 = cyc;
    endtask

    task automatic goto_k(input int k);
        while (now_k() < k) tick();
    endtask

    task automatic wait_pulse(input int n_before, input int limit);
        int t;
        t = 0;
        while (pulse_cnt == n_before && t < limit) begin
            tick();
            t++;
        end
        repeat (3) tick();
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c % 4] = 1'b0;
        return v;
    endfunction

    // Interval in which key_valid is high for a key in column c held from interval p,
    // with scanning restarted at interval origin on column col0.
    function automatic int pred_pulse(input int origin, input int col0, input int p, input int c);
        for (int w = 0; w < 64; w++)
            if ((col0 + w) % 4 == c && origin + SD*w + SD - 1 - LAT >= p)
                return origin + SD*w + SD + DB;
        return -1;
    endfunction

    // First interval of renewed scanning after all keys go up at interval r
    function automatic int pred_resume(input int r);
        return r + LAT + 1 + DB;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        pressed = 16'h0000;
        repeat (3) tick();
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL reset_cols got=%b exp=1110", cols); end
        n_cmp++; if (s1 !== 4'h0) begin n_bad++; $display("FAIL reset_s1 got=%h exp=0", s1); end
        n_cmp++; if (s2 !== 4'h0) begin n_bad++; $display("FAIL reset_s2 got=%h exp=0", s2); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_kv got=%b exp=0", key_valid); end
        reset = 1'b1;
        cyc0 = cyc;
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if (cols !== col_drive(k / SD)) begin
                n_bad++;
                $display("FAIL scan_walk k=%0d got=%b exp=%b", k, cols, col_drive(k / SD));
            end
            tick();
        end
    endtask

    task automatic test_clean_press();
        int n0, pred, r, res;
        do_reset();
        n0 = pulse_cnt;
        pred = pred_pulse(0, 0, 0, 2);
        pressed[6] = 1'b1;
        wait_pulse(n0, 100);
        n_cmp++; if (pulse_cnt - n0 != 1) begin n_bad++; $display("FAIL clean_pulses got=%0d exp=1", pulse_cnt - n0); end
        n_cmp++; if (pulse_k != pred) begin n_bad++; $display("FAIL clean_latency got=%0d exp=%0d", pulse_k, pred); end
        n_cmp++; if (s1 !== 4'h6) begin n_bad++; $display("FAIL clean_s1 got=%h exp=6", s1); end
        n_cmp++; if (s2 !== 4'h0) begin n_bad++; $display("FAIL clean_s2 got=%h exp=0", s2); end
        repeat (50) tick();
        n_cmp++; if (pulse_cnt - n0 != 1) begin n_bad++; $display("FAIL clean_hold got=%0d exp=1", pulse_cnt - n0); end
        pressed = 16'h0000;
        r = now_k();
        res = pred_resume(r);
        goto_k(res - 1);
        n_cmp++; if (cols !== 4'b1011) begin n_bad++; $display("FAIL clean_frozen got=%b exp=1011", cols); end
        tick();
        n_cmp++; if (cols !== 4'b0111) begin n_bad++; $display("FAIL clean_resume got=%b exp=0111", cols); end
        n_cmp++; if (s1 !== 4'h6) begin n_bad++; $display("FAIL clean_s1_kept got=%h exp=6", s1); end
    endtask

    task automatic test_bounce();
        int n0, g, pred;
        do_reset();
        n0 = pulse_cnt;
        pressed[0] = 1'b1;
        g = SD + 4 - LAT;
        goto_k(g);
        glitch = 1'b1;
        tick();
        glitch = 1'b0;
        pred = g + LAT + 1 + SD + DB;
        wait_pulse(n0, 100);
        n_cmp++; if (pulse_cnt - n0 != 1) begin n_bad++; $display("FAIL bounce_pulses got=%0d exp=1", pulse_cnt - n0); end
        n_cmp++; if (pulse_k != pred) begin n_bad++; $display("FAIL bounce_latency got=%0d exp=%0d", pulse_k, pred); end
        n_cmp++; if (s1 !== 4'h1) begin n_bad++; $display("FAIL bounce_s1 got=%h exp=1", s1); end
        pressed = 16'h0000;
        repeat (20) tick();
    endtask

    task automatic test_sequence();
        int n0, pred, r, res;
        do_reset();
        n0 = pulse_cnt;
        pred = pred_pulse(0, 0, 0, 3);
        pressed[3] = 1'b1;
        wait_pulse(n0, 100);
        n_cmp++; if (pulse_k != pred) begin n_bad++; $display("FAIL seq_a_latency got=%0d exp=%0d", pulse_k, pred); end
        n_cmp++; if (s1 !== 4'hA) begin n_bad++; $display("FAIL seq_a_s1 got=%h exp=a", s1); end
        pressed = 16'h0000;
        r = now_k();
        res = pred_resume(r);
        goto_k(res - 1);
        n_cmp++; if (cols !== 4'b0111) begin n_bad++; $display("FAIL seq_frozen got=%b exp=0111", cols); end
        tick();
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL seq_wrap got=%b exp=1110", cols); end
        n0 = pulse_cnt;
        pred = pred_pulse(res, 0, res, 3);
        pressed[15] = 1'b1;
        wait_pulse(n0, 100);
        n_cmp++; if (pulse_cnt - n0 != 1) begin n_bad++; $display("FAIL seq_d_pulses got=%0d exp=1", pulse_cnt - n0); end
        n_cmp++; if (pulse_k != pred) begin n_bad++; $display("FAIL seq_d_latency got=%0d exp=%0d", pulse_k, pred); end
        n_cmp++; if (s1 !== 4'hD) begin n_bad++; $display("FAIL seq_s1 got=%h exp=d", s1); end
        n_cmp++; if (s2 !== 4'hA) begin n_bad++; $display("FAIL seq_s2 got=%h exp=a", s2); end
        pressed = 16'h0000;
        r = now_k();
        goto_k(pred_resume(r));
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL seq_wrap2 got=%b exp=1110", cols); end
        n_cmp++; if (s1 !== 4'hD || s2 !== 4'hA) begin n_bad++; $display("FAIL seq_hist_kept got=%h%h exp=da", s1, s2); end
    endtask

    task automatic test_invalid();
        int n0, pred;
        do_reset();
        n0 = pulse_cnt;
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 8 || k == 24) begin
                n_cmp++;
                if (cols !== col_drive(k / SD)) begin
                    n_bad++;
                    $display("FAIL multi_advance k=%0d got=%b exp=%b", k, cols, col_drive(k / SD));
                end
            end
            tick();
        end
        n_cmp++; if (pulse_cnt != n0) begin n_bad++; $display("FAIL multi_pulses got=%0d exp=0", pulse_cnt - n0); end
        n_cmp++; if (s1 !== 4'h0) begin n_bad++; $display("FAIL multi_s1 got=%h exp=0", s1); end
        do_reset();
        n0 = pulse_cnt;
        pred = pred_pulse(0, 0, 0, 1);
        pressed[1] = 1'b1;
        wait_pulse(n0, 100);
        n_cmp++; if (pulse_k != pred || s1 !== 4'h2) begin n_bad++; $display("FAIL held_first got=%0d/%h exp=%0d/2", pulse_k, s1, pred); end
        n0 = pulse_cnt;
        pressed[4] = 1'b1;
        repeat (30) tick();
        n_cmp++; if (pulse_cnt != n0) begin n_bad++; $display("FAIL held_other_pulses got=%0d exp=0", pulse_cnt - n0); end
        n_cmp++; if (s1 !== 4'h2) begin n_bad++; $display("FAIL held_other_s1 got=%h exp=2", s1); end
        n_cmp++; if (cols !== 4'b1101) begin n_bad++; $display("FAIL held_frozen got=%b exp=1101", cols); end
        pressed = 16'h0000;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        int n0, pred, r, res, det;
        do_reset();
        n0 = pulse_cnt;
        pressed[6] = 1'b1;
        wait_pulse(n0, 100);
        n_cmp++; if (s1 !== 4'h6) begin n_bad++; $display("FAIL mid_pre_s1 got=%h exp=6", s1); end
        pressed = 16'h0000;
        r = now_k();
        res = pred_resume(r);
        goto_k(res);
        n0 = pulse_cnt;
        pressed[5] = 1'b1;
        pred = pred_pulse(res, 3, res, 1);
        det = pred - DB;
        goto_k(det + 5);
        reset = 1'b0;
        tick();
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL mid_kv got=%b exp=0", key_valid); end
        n_cmp++; if (s1 !== 4'h0 || s2 !== 4'h0) begin n_bad++; $display("FAIL mid_hist got=%h%h exp=00", s1, s2); end
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL mid_cols got=%b exp=1110", cols); end
        repeat (4) tick();
        pressed = 16'h0000;
        reset = 1'b1;
        cyc0 = cyc;
        repeat (10) tick();
        n_cmp++; if (pulse_cnt != n0) begin n_bad++; $display("FAIL mid_pulses got=%0d exp=0", pulse_cnt - n0); end
    endtask

    task automatic test_random_keys();
        int order [16];
        int n0, p, idx, pred, r, j, tmp;
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            idx = order[i];
            do_reset();
            n0 = pulse_cnt;
            p = int'($urandom_range(15, 0));
            goto_k(p);
            pressed[idx] = 1'b1;
            pred = pred_pulse(0, 0, p, idx % 4);
            wait_pulse(n0, 150);
            n_cmp++; if (pulse_cnt - n0 != 1) begin n_bad++; $display("FAIL rnd_pulses key=%0d got=%0d exp=1", idx, pulse_cnt - n0); end
            n_cmp++; if (pulse_k != pred) begin n_bad++; $display("FAIL rnd_latency key=%0d p=%0d got=%0d exp=%0d", idx, p, pulse_k, pred); end
            n_cmp++; if (s1 !== legend[idx]) begin n_bad++; $display("FAIL rnd_s1 key=%0d got=%h exp=%h", idx, s1, legend[idx]); end
            pressed = 16'h0000;
            r = now_k();
            goto_k(pred_resume(r));
            n_cmp++; if (cols !== col_drive(idx % 4 + 1)) begin n_bad++; $display("FAIL rnd_resume key=%0d got=%b exp=%b", idx, cols, col_drive(idx % 4 + 1)); end
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_invalid();
        test_reset_mid();
        test_random_keys();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
